// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds state/owner encodings and the registered memory request bundle.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_WAIT = 2'b01,
        DM_WAIT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } owner_t;

    typedef struct packed {
        logic                  we_re;
        logic [3:0]            mask;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter that flags an unanswered memory request.
// Used by mem_port_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (busy && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = busy & (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// Define MEM_ARB_TIMEOUT_EN to abort requests the memory never answers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we_re,
    input  logic [3:0]        dm_mask,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we_re,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t        state, state_nx;
    owner_t        own_q, own_nx;
    mem_req_t      req_q, req_nx;
    logic          on_q, on_nx;
    logic [SW-1:0] starve_q, starve_nx;
    logic          grant;
    logic          tmo;

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    mem_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (grant),
        .busy   (state != IDLE),
        .expired(expired)
    );

    // A completion in the limit cycle wins over the abort.
    assign tmo         = expired & ~mem_valid;
    assign timeout_err = tmo;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            own_q    <= OWN_NONE;
            req_q    <= '0;
            on_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state    <= state_nx;
            own_q    <= own_nx;
            req_q    <= req_nx;
            on_q     <= on_nx;
            starve_q <= starve_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        own_nx    = own_q;
        req_nx    = req_q;
        on_nx     = on_q;
        starve_nx = starve_q;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                // Fetch is forced through once data has won too often.
                if (dm_req && !(if_req && starve_q == STARVE_LIM)) begin
                    grant    = 1'b1;
                    state_nx = DM_WAIT;
                    own_nx   = OWN_DM;
                    on_nx    = 1'b1;
                    req_nx   = '{dm_we_re, dm_mask, dm_addr, dm_wdata};
                    if (!if_req) begin
                        starve_nx = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_nx = starve_q + 1'b1;
                    end
                end else if (if_req) begin
                    grant     = 1'b1;
                    state_nx  = IF_WAIT;
                    own_nx    = OWN_IF;
                    on_nx     = 1'b1;
                    req_nx    = '{1'b0, MASK_WORD, if_addr, req_q.wdata};
                    starve_nx = '0;
                end else begin
                    starve_nx = '0;
                end
            end
            IF_WAIT, DM_WAIT: begin
                if (mem_valid || tmo) begin
                    state_nx = IDLE;
                    own_nx   = OWN_NONE;
                    on_nx    = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                own_nx   = OWN_NONE;
                on_nx    = 1'b0;
            end
        endcase
    end

    assign if_valid = (state == IF_WAIT) & (mem_valid | tmo);
    assign dm_valid = (state == DM_WAIT) & (mem_valid | tmo);
    assign if_rdata = (state == IF_WAIT && mem_valid) ? mem_rdata : '0;
    assign dm_rdata = (state == DM_WAIT && mem_valid) ? mem_rdata : '0;

    assign mem_req   = on_q;
    assign mem_we_re = req_q.we_re;
    assign mem_mask  = req_q.mask;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign owner     = own_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model.
// Define MEM_ARB_TIMEOUT_EN to also exercise the wait timeout.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we_re;
    logic [3:0]  dm_mask;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we_re;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [1:0]  owner;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SMAX),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we_re   (dm_we_re),
        .dm_mask    (dm_mask),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_valid   (dm_valid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we_re  (mem_we_re),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .owner      (owner)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who holds the port, what it asked for,
    // how many data wins in a row happened while fetch was waiting.
    int          m_own, n_own;
    logic        m_we, n_we;
    logic [3:0]  m_mask, n_mask;
    logic [31:0] m_addr, n_addr, m_wd, n_wd;
    int          m_starve, n_starve, m_wait, n_wait;
    bit          m_on = 0, n_on;

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                bit          to_hit;
                logic        e_if, e_dm;
                to_hit = 0;
`ifdef MEM_ARB_TIMEOUT_EN
                to_hit = (m_own != 0) && (m_wait == TO - 1) && !mem_valid;
                chk("m_terr", 32'(timeout_err), 32'(to_hit));
`endif
                e_if = (m_own == 1) && (mem_valid || to_hit);
                e_dm = (m_own == 2) && (mem_valid || to_hit);
                chk("m_req", 32'(mem_req), 32'(m_own != 0));
                chk("m_owner", 32'(owner), 32'(m_own));
                chk("m_ifv", 32'(if_valid), 32'(e_if));
                chk("m_dmv", 32'(dm_valid), 32'(e_dm));
                chk("m_ifd", if_rdata, (e_if && mem_valid) ? mem_rdata : 0);
                chk("m_dmd", dm_rdata, (e_dm && mem_valid) ? mem_rdata : 0);
                if (m_own != 0) begin
                    chk("m_we", 32'(mem_we_re), 32'(m_we));
                    chk("m_mask", 32'(mem_mask), 32'(m_mask));
                    chk("m_addr", mem_addr, m_addr);
                    chk("m_wd", mem_wdata, m_wd);
                end
                n_own = m_own; n_we = m_we; n_mask = m_mask;
                n_addr = m_addr; n_wd = m_wd;
                n_starve = m_starve; n_wait = m_wait + 1;
                if (m_own != 0) begin
                    if (mem_valid || to_hit) n_own = 0;
                end else if (dm_req && !(if_req && m_starve == SMAX)) begin
                    n_own = 2; n_we = dm_we_re; n_mask = dm_mask;
                    n_addr = dm_addr; n_wd = dm_wdata; n_wait = 0;
                    n_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                end else if (if_req) begin
                    n_own = 1; n_we = 0; n_mask = 4'hF;
                    n_addr = if_addr; n_wait = 0; n_starve = 0;
                end else begin
                    n_starve = 0;
                end
            end
            n_on = m_on;
            if (rst === 1'b0) begin
                n_own = 0; n_starve = 0; n_wait = 0; n_on = 1;
            end
            @(posedge clk);
            m_own = n_own; m_we = n_we; m_mask = n_mask;
            m_addr = n_addr; m_wd = n_wd; m_starve = n_starve;
            m_wait = n_wait; m_on = n_on;
        end
    end

    int exp_own [6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        rst = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we_re = 0;
        dm_mask = 0; dm_addr = 0; dm_wdata = 0; mem_valid = 0; mem_rdata = 0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_own", 32'(owner), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_mask", 32'(mem_mask), 0);
        chk("rst_we", 32'(mem_we_re), 0);
        chk("rst_wd", mem_wdata, 0);
        chk("rst_ifd", if_rdata, 0);
        rst = 1;
        tick();

        // Single fetch, memory answers two cycles after mem_req.
        if_req = 1; if_addr = 32'h10;
        tick();
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_we", 32'(mem_we_re), 0);
        chk("t1_mask", 32'(mem_mask), 32'hF);
        chk("t1_own", 32'(owner), 1);
        tick();
        tick();
        chk("t1_hold", mem_addr, 32'h10);
        mem_valid = 1; mem_rdata = 32'h93;
        @(negedge clk);
        chk("t1_ifv", 32'(if_valid), 1);
        chk("t1_ifd", if_rdata, 32'h93);
        tick();
        mem_valid = 0; if_req = 0;
        chk("t1_own0", 32'(owner), 0);
        tick();
        chk("t1_idle", 32'(mem_req), 0);

        // Simultaneous requests: data first, then fetch.
        dm_req = 1; dm_we_re = 1; dm_addr = 32'h100;
        dm_wdata = 32'hCAFE_F00D; dm_mask = 4'h3;
        if_req = 1; if_addr = 32'h20;
        tick();
        chk("t2_own", 32'(owner), 2);
        chk("t2_we", 32'(mem_we_re), 1);
        chk("t2_mask", 32'(mem_mask), 3);
        chk("t2_wd", mem_wdata, 32'hCAFE_F00D);
        mem_valid = 1; mem_rdata = 32'h1;
        @(negedge clk);
        chk("t2_dmv", 32'(dm_valid), 1);
        chk("t2_ifv", 32'(if_valid), 0);
        tick();
        mem_valid = 0; dm_req = 0; dm_we_re = 0;
        chk("t2_gap", 32'(mem_req), 0);
        tick();
        chk("t2_own_if", 32'(owner), 1);
        chk("t2_ifaddr", mem_addr, 32'h20);
        mem_valid = 1; mem_rdata = 32'h2;
        tick();
        mem_valid = 0; if_req = 0;

        // Starvation: fetch wins the fifth grant, then data again.
        dm_req = 1; if_req = 1; dm_addr = 32'h200; if_addr = 32'h40;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3_own", 32'(owner), 32'(exp_own[k]));
            mem_valid = 1; mem_rdata = 32'(k + 5);
            @(negedge clk);
            chk("t3_v", {30'd0, dm_valid, if_valid}, 32'(exp_own[k]));
            tick();
            mem_valid = 0;
        end
        dm_req = 0; if_req = 0;
        tick();

        // Stray completions in IDLE and in DM_WAIT.
        mem_valid = 1; mem_rdata = 32'hDEAD;
        @(negedge clk);
        chk("t4_idle_if", 32'(if_valid), 0);
        chk("t4_idle_dm", 32'(dm_valid), 0);
        tick();
        mem_valid = 0;
        chk("t4_idle_req", 32'(mem_req), 0);
        dm_req = 1; if_req = 1; dm_we_re = 0; dm_addr = 32'h300;
        tick();
        chk("t4_own", 32'(owner), 2);
        tick();
        mem_valid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("t4_dmv", 32'(dm_valid), 1);
        chk("t4_dmd", dm_rdata, 32'h77);
        chk("t4_ifv", 32'(if_valid), 0);
        tick();
        mem_valid = 0; dm_req = 0;

        // Reset in the middle of a fetch, late completion ignored.
        tick();
        chk("t5_own", 32'(owner), 1);
        rst = 0;
        tick();
        rst = 1; if_req = 0; mem_valid = 1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("t5_req", 32'(mem_req), 0);
        chk("t5_ifv", 32'(if_valid), 0);
        chk("t5_own0", 32'(owner), 0);
        chk("t5_addr", mem_addr, 0);
        tick();
        mem_valid = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort in the eighth wait cycle.
        if_req = 1; if_addr = 32'h80;
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_ifv", 32'(if_valid), 32'(i == 7));
            chk("t6_terr", 32'(timeout_err), 32'(i == 7));
            if (i == 7) chk("t6_ifd", if_rdata, 0);
            tick();
        end
        if_req = 0;
        chk("t6_req", 32'(mem_req), 0);
        tick();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
